// File: rtl/mem_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian byte stream,
// writes the payload words to instruction memory and then releases the core.
module mem_loader #(
  parameter int unsigned MEM_SIZE  = 8192,
  parameter logic [31:0] MEM_START = 32'h0000_0000
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        instr_we,
  output logic [3:0]  instr_be,
  output logic [31:0] instr_addr,
  output logic [31:0] instr_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_SIZE / 4);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] len_q;
  logic [31:0] idx_q;
  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;
  logic [31:0] idx_inc;

  always_comb begin
    accept    = byte_valid && byte_ready;
    last_byte = accept && (cnt_q == 2'd3);
    word_full = {byte_data, word_q[23:0]};
    idx_inc   = idx_q + 32'd1;
    state_d   = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if (word_full == '0)
            state_d = S_DONE;
          else if (word_full > MAX_WORDS)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA:  if (last_byte) state_d = S_WR;
      S_WR:    state_d = (idx_inc == len_q) ? S_DONE : S_DATA;
      default: state_d = state_q;
    endcase
  end

  // byte_ready follows the next state so the registered flag matches the state it qualifies
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q     <= S_LEN;
      cnt_q       <= '0;
      word_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      byte_ready  <= 1'b0;
      instr_we    <= 1'b0;
      instr_be    <= '0;
      instr_addr  <= MEM_START;
      instr_wdata <= '0;
      core_rst_n  <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ready <= (state_d == S_LEN) || (state_d == S_DATA);
      instr_we   <= 1'b0;
      instr_be   <= '0;

      if (accept) begin
        cnt_q                       <= cnt_q + 2'd1;
        word_q[{cnt_q, 3'b000} +: 8] <= byte_data;
      end

      if (state_q == S_LEN && last_byte) begin
        len_q <= word_full;
        idx_q <= '0;
      end

      if (state_q == S_DATA && last_byte) begin
        instr_we    <= 1'b1;
        instr_be    <= '1;
        instr_addr  <= MEM_START + {idx_q[29:0], 2'b00};
        instr_wdata <= word_full;
      end

      if (state_q == S_WR)
        idx_q <= idx_inc;

      if (state_q == S_DONE) begin
        load_done  <= 1'b1;
        core_rst_n <= 1'b1;
      end

      if (state_q == S_ERR)
        load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: scoreboarded write checks plus status/handshake checks.
module tb_mem_loader;

  logic        clk_sys    = 1'b0;
  logic        rst_sys_n  = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data  = '0;
  logic        byte_ready;
  logic        instr_we;
  logic [3:0]  instr_be;
  logic [31:0] instr_addr;
  logic [31:0] instr_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  int          vectors     = 0;
  int          miscompares = 0;
  int          writes      = 0;
  logic [31:0] last_addr   = '0;
  logic        prev_we     = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  bit          gaps        = 1'b0;

  always #5 clk_sys = ~clk_sys;

  mem_loader #(
    .MEM_SIZE (8192),
    .MEM_START(32'h0000_0000)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_sys_n  (rst_sys_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .instr_we   (instr_we),
    .instr_be   (instr_be),
    .instr_addr (instr_addr),
    .instr_wdata(instr_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every instr_we pulse is matched against the scoreboard
  always @(negedge clk_sys) begin
    if (rst_sys_n && instr_we) begin
      writes++;
      last_addr = instr_addr;
      check("we_single_cycle", {31'b0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, instr_we}, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", instr_addr, exp_e[63:32]);
        check("wr_data", instr_wdata, exp_e[31:0]);
        check("wr_be", {28'b0, instr_be}, 32'hF);
      end
    end
    prev_we = rst_sys_n && instr_we;
  end

  function automatic logic [31:0] pat(input int unsigned i);
    logic [15:0] l;
    l = i[15:0];
    return {~l, l};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        @(negedge clk_sys);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 1000) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 1000) check("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk_sys);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] s;
      s = w >> (8 * k);
      send_byte(s[7:0]);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst_sys_n  = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    writes    = 0;
    rst_sys_n = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  initial begin
    // Reset values, sampled while reset is held
    do_reset();
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_instr_we", {31'b0, instr_we}, 32'd0);
    check("rst_instr_be", {28'b0, instr_be}, 32'd0);
    check("rst_instr_addr", instr_addr, 32'h0);
    check("rst_instr_wdata", instr_wdata, 32'h0);
    check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("rst_load_done", {31'b0, load_done}, 32'd0);
    check("rst_load_err", {31'b0, load_err}, 32'd0);
    rst_sys_n = 1'b1;

    // Length 2, gapless
    do_reset();
    push_exp(32'h0, 32'h4433_2211);
    push_exp(32'h4, 32'h8877_6655);
    send_word(32'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    check("t1_we_in_wr", {31'b0, instr_we}, 32'd1);
    check("t1_done_during_wr", {31'b0, load_done}, 32'd0);
    check("t1_core_rst_during_wr", {31'b0, core_rst_n}, 32'd0);
    repeat (2) @(negedge clk_sys);
    check("t1_load_done", {31'b0, load_done}, 32'd1);
    check("t1_core_rst_n", {31'b0, core_rst_n}, 32'd1);
    check("t1_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("t1_writes", writes, 32'd2);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // Length 0
    do_reset();
    send_word(32'd0);
    repeat (3) @(negedge clk_sys);
    check("t2_load_done", {31'b0, load_done}, 32'd1);
    check("t2_core_rst_n", {31'b0, core_rst_n}, 32'd1);
    check("t2_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("t2_load_err", {31'b0, load_err}, 32'd0);
    check("t2_writes", writes, 32'd0);

    // Length 2049 exceeds capacity; later bytes must not be taken
    do_reset();
    send_word(32'd2049);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (4) @(negedge clk_sys);
    check("t3_load_err", {31'b0, load_err}, 32'd1);
    check("t3_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("t3_load_done", {31'b0, load_done}, 32'd0);
    check("t3_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("t3_writes", writes, 32'd0);
    byte_valid = 1'b0;

    // Full-capacity image; a byte offered during the write cycle is held
    do_reset();
    send_word(32'd2048);
    for (int unsigned i = 0; i < 2048; i++) begin
      push_exp(4 * i, pat(i));
      send_word(pat(i));
      if (i == 0) begin
        check("t4_ready_low_in_wr", {31'b0, byte_ready}, 32'd0);
        check("t4_we_in_wr", {31'b0, instr_we}, 32'd1);
      end
    end
    repeat (2) @(negedge clk_sys);
    check("t4_last_addr", last_addr, 32'h0000_1FFC);
    check("t4_writes", writes, 32'd2048);
    check("t4_load_done", {31'b0, load_done}, 32'd1);
    check("t4_load_err", {31'b0, load_err}, 32'd0);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // Length 3 with random valid gaps
    do_reset();
    gaps = 1'b1;
    push_exp(32'h0, 32'hDEAD_BEEF);
    push_exp(32'h4, 32'h0123_4567);
    push_exp(32'h8, 32'hFEDC_BA98);
    send_word(32'd3);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    send_word(32'hFEDC_BA98);
    gaps = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("t5_writes", writes, 32'd3);
    check("t5_load_done", {31'b0, load_done}, 32'd1);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // Reset after two payload bytes, then a fresh length-1 image
    do_reset();
    send_word(32'd2);
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    check("t6_done_cleared", {31'b0, load_done}, 32'd0);
    push_exp(32'h0, 32'hDDCC_BBAA);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    repeat (2) @(negedge clk_sys);
    check("t6_writes", writes, 32'd1);
    check("t6_load_done", {31'b0, load_done}, 32'd1);
    check("t6_core_rst_n", {31'b0, core_rst_n}, 32'd1);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time program loader upstream of the instruction ROM write port (instr_we / instr_be / instr_addr / instr_wdata).
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to sequential word addresses.
- Holds the core in reset until the image is fully written.

Parameters:
- MEM_SIZE, 8192, memory size in bytes; max image = MEM_SIZE/4 words.
- MEM_START, 32'h00000000, byte address of the first word written.

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  input byte valid.
- byte_data  in  8  input byte.
- byte_ready  out  1  loader accepts byte_data this cycle when byte_valid && byte_ready.
- instr_we  out  1  write strobe to instruction memory, one cycle per word.
- instr_be  out  4  byte enables; 4'hF when instr_we = 1, else 4'h0.
- instr_addr  out  32  word-aligned write address.
- instr_wdata  out  32  write data.
- core_rst_n  out  1  active-low reset to the core; released when the load completes.
- load_done  out  1  image fully written (sticky).
- load_err  out  1  image length exceeds capacity (sticky).

Behaviour:
- One clock; reset is asynchronous and active-low on rst_sys_n.
- Reset values: byte_ready = 0, instr_we = 0, instr_be = 0, instr_addr = MEM_START, instr_wdata = 0, core_rst_n = 0, load_done = 0, load_err = 0.
- All outputs are registered.
- Stream format: a 4-byte length word L (word count, LSB first), followed by L payload words, each LSB first.
- Byte assembly: the k-th accepted byte of a word (k = 0..3) goes to bits [8k+7:8k]. A 2-bit byte counter wraps 3 -> 0 on word completion.
- State machine (S_LEN after reset):
  - S_LEN: byte_ready = 1. Collect 4 bytes into L. On the 4th byte:
    - L == 0 -> S_DONE;
    - L > MEM_SIZE/4 -> S_ERR;
    - otherwise -> S_DATA, with word index idx = 0.
  - S_DATA: byte_ready = 1. Collect 4 bytes. On the 4th byte -> S_WR.
  - S_WR: byte_ready = 0. Exactly one cycle with instr_we = 1, instr_be = 4'hF, instr_addr = MEM_START + 4*idx, instr_wdata = assembled word. Then idx = idx + 1. If the new idx == L -> S_DONE, else -> S_DATA.
  - S_DONE: byte_ready = 0, load_done = 1, core_rst_n = 1. Both assert in the cycle after S_DONE is entered and remain until reset.
  - S_ERR: byte_ready = 0, load_err = 1. core_rst_n stays 0 until reset.
- Throughput: 5 cycles per word minimum (4 byte cycles + 1 write cycle) when byte_valid is held high.
- Stalls:
  - byte_valid low in S_LEN or S_DATA holds all state; no timeout.
  - Bytes presented in S_WR, S_DONE or S_ERR are not accepted. The upstream must hold them (valid/ready rule).
- Boundary condition: L = MEM_SIZE/4 is legal. The last write goes to MEM_START + MEM_SIZE - 4, and idx never exceeds L.
- Reset mid-operation: state, byte counter, idx and partial word are cleared. The next accepted byte is byte 0 of a new length word. Words already written remain in memory.
- instr_wdata and instr_addr may hold stale values outside S_WR; consumers sample them only when instr_we = 1.

Test Plan:
- Length 2, payload bytes 11 22 33 44 55 66 77 88, byte_valid always high -> write 32'h44332211 @ 0x0, then write 32'h88776655 @ 0x4. Each instr_we pulse lasts one cycle with be = F. load_done and core_rst_n rise one cycle after the second write.
- Length 0 (00 00 00 00) -> no instr_we pulse; load_done = 1; core_rst_n = 1; byte_ready = 0 thereafter.
- Length 2049 with MEM_SIZE = 8192 (bytes 01 08 00 00) -> load_err = 1, core_rst_n stays 0, no writes, byte_ready = 0.
- Length 2048 with full payload -> the last write goes to 0x1FFC and load_done = 1. Also check that a byte offered during S_WR is held and then accepted.
- Random byte_valid gaps (50% duty), length 3 -> same three words and addresses as with the gapless stream; no byte is lost or duplicated.
- Assert rst_sys_n low after 2 payload bytes, release, then send a fresh length-1 image AA BB CC DD -> a single write of 32'hDDCCBBAA @ 0x0, then load_done = 1.
